// File: rtl/npu_pkg.sv
// Shared NPU definitions: fetch FSM states, default slice geometry,
// kernel codes and slice buffer constants.
package npu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DEL   = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

  localparam int NPU_DATA_WIDTH   = 16;
  localparam int NPU_COLUMN_WIDTH = 9;
  localparam int NPU_IMAGE_COUNT  = 10;
  localparam int NPU_TILE_COUNT   = 4;

  localparam logic [2:0] KERNEL_3 = 3'd3;
  localparam logic [2:0] KERNEL_6 = 3'd6;

  // Slice buffer geometry: one kernel-6 slice is the largest thing it holds.
  localparam int SLICE_BUF_ROWS       = NPU_IMAGE_COUNT * NPU_TILE_COUNT;
  localparam int SLICE_BUF_ADDR_WIDTH = $clog2(SLICE_BUF_ROWS);
  localparam int SLICE_FIFO_DEPTH     = 4;

  function automatic logic kernel_legal(input logic [2:0] k);
    return (k == KERNEL_3) || (k == KERNEL_6);
  endfunction

endpackage

// File: rtl/slice_fetch_sync_fifo.sv
// Small synchronous FIFO with fall-through read port; DEPTH must be a
// power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array; contents need no reset because empty gates the output.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/slice_fetch.sv
// Slice fetcher: requests rows from the slice buffer, tags them with
// row/tile indices, queues them for the PE array, then retires the slice.
module slice_fetch
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH   = NPU_DATA_WIDTH,
  parameter int COLUMN_WIDTH = NPU_COLUMN_WIDTH,
  parameter int IMAGE_COUNT  = NPU_IMAGE_COUNT,
  parameter int TILE_COUNT   = NPU_TILE_COUNT
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               sudo_reset,
  input  logic                               start,
  input  logic [2:0]                         kernel,
  output logic                               image_read,
  input  logic [COLUMN_WIDTH*DATA_WIDTH-1:0] image_data,
  input  logic                               image_valid,
  output logic                               im_valid_del,
  output logic [COLUMN_WIDTH*DATA_WIDTH-1:0] pe_data,
  output logic                               pe_valid,
  input  logic                               pe_ready,
  output logic [3:0]                         pe_row,
  output logic [2:0]                         pe_tile,
  output logic                               busy,
  output logic                               fetch_done,
  output logic                               err
);

  localparam int MAX_TOTAL = IMAGE_COUNT * TILE_COUNT;
  localparam int CNT_W     = $clog2(MAX_TOTAL + 1);
  localparam int PIX_W     = COLUMN_WIDTH * DATA_WIDTH;
  localparam int ENTRY_W   = PIX_W + 7;
  localparam int FIFO_CW   = $clog2(SLICE_FIFO_DEPTH + 1);

  fetch_state_t     state;
  fetch_state_t     state_next;
  logic             any_reset;
  logic [CNT_W-1:0] total;
  logic [CNT_W-1:0] rx_count;
  logic [CNT_W:0]   rx_plus_pending;
  logic [3:0]       row_idx;
  logic [2:0]       tile_idx;
  logic             read_q;
  logic             start_ok;
  logic             accept_window;
  logic             push;
  logic             pop;
  logic             err_set;
  logic [ENTRY_W-1:0] fifo_in;
  logic [ENTRY_W-1:0] fifo_out;
  logic [FIFO_CW-1:0] fifo_count;
  logic               fifo_full;
  logic               fifo_empty;

  assign any_reset     = reset || sudo_reset;
  assign start_ok      = (state == IDLE) && start && kernel_legal(kernel);
  assign accept_window = (state == FETCH) && (rx_count < total);
  assign push          = image_valid && accept_window && !fifo_full;
  assign pop           = pe_valid && pe_ready;
  assign err_set       = ((state == IDLE) && start && !kernel_legal(kernel))
                      || (image_valid && !accept_window)
                      || (image_valid && accept_window && fifo_full);

  // A request still in flight from last cycle counts toward the total so we
  // never ask for more rows than the slice holds.
  assign rx_plus_pending = {1'b0, rx_count} + (CNT_W + 1)'(read_q);
  assign image_read      = (state == FETCH)
                        && (fifo_count <= FIFO_CW'(1))
                        && (rx_plus_pending < {1'b0, total});

  assign fifo_in  = {image_data, row_idx, tile_idx};
  assign pe_valid = !fifo_empty;
  assign pe_data  = pe_valid ? fifo_out[ENTRY_W-1:7] : '0;
  assign pe_row   = pe_valid ? fifo_out[6:3] : '0;
  assign pe_tile  = pe_valid ? fifo_out[2:0] : '0;
  assign busy     = (state != IDLE);

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (SLICE_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (any_reset),
    .push      (push),
    .push_data (fifo_in),
    .pop       (pop),
    .pop_data  (fifo_out),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // FSM state register; either reset abandons any partial slice.
  always_ff @(posedge clk) begin
    if (any_reset) state <= IDLE;
    else           state <= state_next;
  end

  // Next-state and single-cycle retire/done pulses.
  always_comb begin
    state_next   = state;
    im_valid_del = 1'b0;
    fetch_done   = 1'b0;
    unique case (state)
      IDLE:  if (start_ok) state_next = FETCH;
      FETCH: if ((rx_count == total) && fifo_empty) state_next = DEL;
      DEL: begin
        im_valid_del = 1'b1;
        state_next   = DONE;
      end
      DONE: begin
        fetch_done = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  // Slice size latch and response counters; only real responses advance them.
  always_ff @(posedge clk) begin
    if (any_reset) begin
      total    <= '0;
      rx_count <= '0;
      row_idx  <= '0;
      tile_idx <= '0;
      read_q   <= 1'b0;
    end else begin
      read_q <= image_read;
      if (start_ok) begin
        total    <= (kernel == KERNEL_6) ? CNT_W'(MAX_TOTAL) : CNT_W'(IMAGE_COUNT);
        rx_count <= '0;
        row_idx  <= '0;
        tile_idx <= '0;
      end else if (push) begin
        rx_count <= rx_count + CNT_W'(1);
        if (row_idx == 4'(IMAGE_COUNT - 1)) begin
          row_idx  <= '0;
          tile_idx <= tile_idx + 3'd1;
        end else begin
          row_idx <= row_idx + 4'd1;
        end
      end
    end
  end

  // Sticky error flag, cleared only by a reset.
  always_ff @(posedge clk) begin
    if (any_reset)    err <= 1'b0;
    else if (err_set) err <= 1'b1;
  end

endmodule

// File: tb/tb_slice_fetch.sv
// Randomized scoreboard bench for slice_fetch: a behavioural slice buffer
// drives responses and queues the expected PE beats; a monitor pops them.
module tb_slice_fetch;

  localparam int IC = 10;
  localparam int TC = 4;
  localparam int PW = 16 * 9;
  localparam int EW = PW + 7;

  logic          clk;
  logic          reset;
  logic          sudo_reset;
  logic          start;
  logic [2:0]    kernel;
  logic          image_read;
  logic [PW-1:0] image_data;
  logic          image_valid;
  logic          im_valid_del;
  logic [PW-1:0] pe_data;
  logic          pe_valid;
  logic          pe_ready;
  logic [3:0]    pe_row;
  logic [2:0]    pe_tile;
  logic          busy;
  logic          fetch_done;
  logic          err;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  logic [EW-1:0] exp_q[$];
  int            exp_total;
  int            k_resp;
  int            extra_resp;
  bit            buf_enable;
  bit            req_pending;
  int            resp_pct;
  int            ignore_until;
  int            ready_mode;
  logic [159:0]  rand_word;

  int            beats;
  int            del_cnt;
  int            done_cnt;
  int            del_cyc;
  int            done_cyc;
  int            fifo_max;
  bit            hold_active;
  logic [PW-1:0] held_data;

  slice_fetch dut (
    .clk          (clk),
    .reset        (reset),
    .sudo_reset   (sudo_reset),
    .start        (start),
    .kernel       (kernel),
    .image_read   (image_read),
    .image_data   (image_data),
    .image_valid  (image_valid),
    .im_valid_del (im_valid_del),
    .pe_data      (pe_data),
    .pe_valid     (pe_valid),
    .pe_ready     (pe_ready),
    .pe_row       (pe_row),
    .pe_tile      (pe_tile),
    .busy         (busy),
    .fetch_done   (fetch_done),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [EW-1:0] actual,
                             input logic [EW-1:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Behavioural slice buffer: answers a request on the following cycle with
  // probability resp_pct once the ignore window is over; also drives pe_ready.
  always @(posedge clk) begin
    #1;
    if (buf_enable) begin
      if (req_pending && (cyc >= ignore_until) && ($urandom_range(99) < resp_pct)) begin
        rand_word   = {$urandom, $urandom, $urandom, $urandom, $urandom};
        image_data  = rand_word[PW-1:0];
        image_valid = 1'b1;
        if (k_resp < exp_total)
          exp_q.push_back({image_data, 4'(k_resp % IC), 3'(k_resp / IC)});
        else
          extra_resp++;
        k_resp++;
      end else begin
        image_valid = 1'b0;
      end
      req_pending = image_read;
      case (ready_mode)
        0:       pe_ready = 1'b1;
        1:       pe_ready = ~pe_ready;
        default: pe_ready = 1'($urandom_range(1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on each accepted beat, checks hold-stable
  // data under backpressure and records pulse timing.
  always @(negedge clk) begin
    if (pe_valid && hold_active)
      checkOutput("hold_stable", EW'(pe_data), EW'(held_data));
    if (pe_valid && pe_ready) begin
      beats++;
      hold_active = 1'b0;
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_beat: got row %0d tile %0d, expected no beat", pe_row, pe_tile);
      end else begin
        checkOutput("beat", {pe_data, pe_row, pe_tile}, exp_q.pop_front());
      end
    end else if (pe_valid) begin
      hold_active = 1'b1;
      held_data   = pe_data;
    end else begin
      hold_active = 1'b0;
    end
    if (im_valid_del) begin del_cnt++; del_cyc = cyc; end
    if (fetch_done)   begin done_cnt++; done_cyc = cyc; end
    if (int'(dut.fifo_count) > fifo_max) fifo_max = int'(dut.fifo_count);
  end

  // One full slice fetch with the given buffer/PE behaviour, then checks.
  task automatic applyStimulus(input logic [2:0] k, input int mode, input int pct,
                               input int ign, input logic exp_err, input bit glitch);
    int  del0;
    int  done0;
    int  gap;
    bit  finished;
    @(negedge clk); #1;
    exp_total    = (k == 3'd6) ? IC * TC : IC;
    k_resp       = 0;
    extra_resp   = 0;
    beats        = 0;
    fifo_max     = 0;
    gap          = 0;
    del0         = del_cnt;
    done0        = done_cnt;
    req_pending  = 1'b0;
    ready_mode   = mode;
    resp_pct     = pct;
    ignore_until = cyc + 1 + ign;
    buf_enable   = 1'b1;
    start        = 1'b1;
    kernel       = k;
    @(negedge clk); #1;
    start  = 1'b0;
    kernel = 3'($urandom_range(7));
    finished = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done_cnt != done0) begin finished = 1'b1; break; end
      if ((ign > 0) && (cyc < ignore_until) && (!image_read || pe_valid)) gap++;
      if (glitch && i == 5) begin start = 1'b1; kernel = 3'($urandom_range(7)); end
      if (glitch && i == 6) start = 1'b0;
      @(negedge clk); #1;
    end
    if (!finished) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL timeout: got no fetch_done, expected one within 3000 cycles");
    end
    @(negedge clk); #1;
    @(negedge clk); #1;
    buf_enable  = 1'b0;
    image_valid = 1'b0;
    pe_ready    = 1'b1;
    checkOutput("beat_count", EW'(beats), EW'(exp_total));
    checkOutput("del_pulses", EW'(del_cnt - del0), EW'(1));
    checkOutput("done_pulses", EW'(done_cnt - done0), EW'(1));
    checkOutput("done_after_del", EW'(done_cyc), EW'(del_cyc + 1));
    checkOutput("queue_drained", EW'(exp_q.size()), EW'(0));
    checkOutput("extra_responses", EW'(extra_resp), EW'(0));
    checkOutput("fifo_max_le3", EW'(fifo_max <= 3), EW'(1));
    checkOutput("busy_after", EW'(busy), EW'(0));
    checkOutput("err_after", EW'(err), EW'(exp_err));
    if (ign > 0) checkOutput("read_held_while_ignored", EW'(gap), EW'(0));
  endtask

  initial begin
    int  bad;
    int  del0;
    reset       = 1'b1;
    sudo_reset  = 1'b0;
    start       = 1'b0;
    kernel      = 3'd0;
    image_data  = '0;
    image_valid = 1'b0;
    pe_ready    = 1'b1;
    buf_enable  = 1'b0;
    req_pending = 1'b0;
    ready_mode  = 0;
    resp_pct    = 100;
    ignore_until = 0;
    exp_total   = 0;
    k_resp      = 0;
    extra_resp  = 0;
    beats       = 0;
    del_cnt     = 0;
    done_cnt    = 0;
    del_cyc     = 0;
    done_cyc    = 0;
    fifo_max    = 0;
    hold_active = 1'b0;
    held_data   = '0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_image_read", EW'(image_read), EW'(0));
    checkOutput("rst_im_valid_del", EW'(im_valid_del), EW'(0));
    checkOutput("rst_pe_valid", EW'(pe_valid), EW'(0));
    checkOutput("rst_pe_fields", {pe_data, pe_row, pe_tile}, EW'(0));
    checkOutput("rst_busy", EW'(busy), EW'(0));
    checkOutput("rst_fetch_done", EW'(fetch_done), EW'(0));
    checkOutput("rst_err", EW'(err), EW'(0));

    $display("[TB] kernel 3, immediate buffer, pe_ready high");
    applyStimulus(3'd3, 0, 100, 0, 1'b0, 1'b0);

    $display("[TB] kernel 6, pe_ready toggling");
    applyStimulus(3'd6, 1, 100, 0, 1'b0, 1'b0);

    $display("[TB] buffer ignores requests for 20 cycles");
    applyStimulus(3'd3, 0, 100, 20, 1'b0, 1'b0);

    $display("[TB] randomized fetches");
    for (int n = 0; n < 6; n++)
      applyStimulus(($urandom_range(1) != 0) ? 3'd6 : 3'd3, $urandom_range(2),
                    $urandom_range(100, 40), 0, 1'b0, 1'b1);

    $display("[TB] illegal kernel 5");
    @(negedge clk); #1;
    start  = 1'b1;
    kernel = 3'd5;
    @(negedge clk); #1;
    start = 1'b0;
    bad   = 0;
    for (int i = 0; i < 5; i++) begin
      if (busy || image_read) bad++;
      @(negedge clk); #1;
    end
    checkOutput("bad_kernel_err", EW'(err), EW'(1));
    checkOutput("bad_kernel_idle", EW'(bad), EW'(0));
    applyStimulus(3'd3, 0, 100, 0, 1'b1, 1'b0);

    $display("[TB] sudo_reset mid-fetch");
    @(negedge clk); #1;
    exp_total   = IC;
    k_resp      = 0;
    extra_resp  = 0;
    beats       = 0;
    req_pending = 1'b0;
    ready_mode  = 0;
    resp_pct    = 100;
    ignore_until = 0;
    buf_enable  = 1'b1;
    start       = 1'b1;
    kernel      = 3'd3;
    @(negedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 200 && beats < 4; i++) begin
      @(negedge clk); #1;
    end
    checkOutput("beats_before_sudo", EW'(beats), EW'(4));
    sudo_reset  = 1'b1;
    buf_enable  = 1'b0;
    image_valid = 1'b0;
    del0        = del_cnt;
    @(negedge clk); #1;
    sudo_reset = 1'b0;
    exp_q.delete();
    checkOutput("sudo_busy", EW'(busy), EW'(0));
    checkOutput("sudo_pe_valid", EW'(pe_valid), EW'(0));
    checkOutput("sudo_image_read", EW'(image_read), EW'(0));
    checkOutput("sudo_err_cleared", EW'(err), EW'(0));
    repeat (20) @(negedge clk);
    #1;
    checkOutput("sudo_no_del", EW'(del_cnt - del0), EW'(0));
    image_valid = 1'b1;
    @(negedge clk); #1;
    image_valid = 1'b0;
    @(negedge clk); #1;
    checkOutput("stray_valid_err", EW'(err), EW'(1));
    checkOutput("stray_valid_busy", EW'(busy), EW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/slice_fetch.md
SLICE_FETCH -- requirements
Module: slice_fetch

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 16, pixel width; COLUMN_WIDTH, default 9, pixels per slice row; IMAGE_COUNT, default 10, rows per tile; TILE_COUNT, default 4, tiles per kernel-6 slice.
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- sudo_reset  in  1  synchronous soft reset, same effect as reset.
- start  in  1  one-cycle pulse that begins a slice fetch.
- kernel  in  3  kernel size, sampled on start; legal values are 3 and 6.
- image_read  out  1  read request to the slice buffer.
- image_data  in  COLUMN_WIDTH*DATA_WIDTH  slice row returned by the buffer.
- image_valid  in  1  image_data is valid this cycle.
- im_valid_del  out  1  one-cycle pulse that tells the buffer to discard the consumed slice.
- pe_data  out  COLUMN_WIDTH*DATA_WIDTH  row sent to the PE array.
- pe_valid  out  1  pe_data, pe_row and pe_tile are valid.
- pe_ready  in  1  PE array accepts the row.
- pe_row  out  4  row index within the tile, 0..IMAGE_COUNT-1.
- pe_tile  out  3  tile index, 0..TILE_COUNT-1.
- busy  out  1  high in every state except IDLE.
- fetch_done  out  1  one-cycle pulse when the fetch completes.
- err  out  1  sticky error flag.

Function
REQ-003 States SHALL be IDLE, FETCH, DEL and DONE.
REQ-004 IDLE->FETCH SHALL occur on start when kernel is 3 or 6.
- kernel is latched on that edge.
- total = IMAGE_COUNT (kernel 3) or IMAGE_COUNT*TILE_COUNT (kernel 6).
REQ-005 A start with any other kernel value SHALL set err and stay in IDLE.
REQ-006 In FETCH, image_read SHALL be asserted combinationally iff all of the following hold:
- fifo_count <= 1;
- rx_count + read_q < total, where read_q is image_read registered from the previous cycle.
REQ-007 The buffer may ignore image_read (slice not yet loaded). The requester SHALL therefore count only image_valid responses (rx_count) and never count requests.
REQ-008 Each image_valid in FETCH with rx_count < total SHALL push {image_data, row, tile} into a 4-entry FIFO and increment rx_count.
- row = rx_count mod IMAGE_COUNT.
- tile = rx_count / IMAGE_COUNT.
REQ-009 An image_valid outside FETCH, or when rx_count == total, SHALL be dropped and SHALL set err.
REQ-010 pe_valid/pe_data/pe_row/pe_tile SHALL present the FIFO head.
- An entry pops on pe_valid && pe_ready.
- pe_data is held stable while pe_valid && !pe_ready.
- Push and pop in the same cycle leave fifo_count unchanged.
REQ-011 Latency SHALL be at least one cycle from image_valid to pe_valid, with first-word fall-through when the FIFO is empty.
REQ-012 FIFO overflow SHALL be impossible by REQ-006 (at most 3 entries occupied); a push while full SHALL set err and drop the data.
REQ-013 FETCH->DEL SHALL occur when rx_count == total and the FIFO is empty.
REQ-014 DEL SHALL assert im_valid_del for exactly one cycle, then go to DONE.
REQ-015 DONE SHALL assert fetch_done for exactly one cycle, then go to IDLE.
REQ-016 start SHALL be ignored outside IDLE.
REQ-017 kernel changes after start SHALL have no effect.
REQ-018 err SHALL clear only on reset or sudo_reset.

Reset
REQ-019 On reset or sudo_reset, including mid-FETCH, the block SHALL:
- go to IDLE;
- clear rx_count, read_q, FIFO pointers, fifo_count and err;
- drive image_read=0, im_valid_del=0, pe_valid=0, pe_data=0, pe_row=0, pe_tile=0, busy=0, fetch_done=0.
REQ-020 A partially fetched slice SHALL NOT be followed by an im_valid_del after reset.

Structure
REQ-021 State encodings and default IMAGE_COUNT/TILE_COUNT SHALL live in a shared package npu_pkg, together with the slice buffer's constants.
REQ-022 The FIFO SHALL be a sub-module named sync_fifo with parameters WIDTH and DEPTH=4, providing count, full and empty.

Verification
REQ-023 Kernel 3, buffer responds the cycle after each request, pe_ready=1:
- exactly 10 pe_valid beats with pe_row 0..9 and pe_tile 0;
- im_valid_del pulses once, fetch_done pulses on the next cycle.
REQ-024 Kernel 6, pe_ready toggling every cycle: 40 beats in order, rows 0..9 for each of tiles 0..3; no data loss; fifo_count never exceeds 3; err stays 0.
REQ-025 Buffer ignores image_read for 20 cycles, then responds:
- image_read stays asserted throughout;
- rx_count stays 0 until the first image_valid;
- the 10 beats still arrive.
REQ-026 start with kernel=5: err=1, busy=0, image_read stays 0; a following start with kernel=3 completes normally with err still 1.
REQ-027 sudo_reset after 4 of 10 rows: next cycle busy=0, pe_valid=0, im_valid_del never pulses; a stray image_valid in IDLE sets err.
